// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline stage that sits directly after the ALU. Each accepted entry
//   holds the ALU result, store data, destination register and the write-back
//   and memory control bits. Entries go into a 2-entry skid buffer that talks to
//   the memory stage with a valid/ready handshake. BEQ-style branches are
//   resolved from the ALU zero flag. A taken branch sends a one-cycle redirect
//   pulse to fetch.
//
// Optional feature macro: EX_MEM_PERF_CNT_EN
//   When this macro is defined, the perf_accepted and perf_stall counter
//   outputs are added.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   flush           synchronous discard of all buffered entries
//   in_valid/ready  handshake from the execute stage (in_ready = count != 2)
//   alu_res, alu_zf ALU result and zero flag
//   store_data      rt value for stores
//   rd_addr, reg_wr destination register and write-back enable
//   mem_rd, mem_wr  load / store controls
//   is_branch       entry is a BEQ
//   br_tgt_in       precomputed branch target
//   out_valid/ready handshake toward the memory stage
//   out_*           registered head entry fields, held while out_valid = 0
//   br_taken        one-cycle redirect pulse
//   br_target       redirect address, meaningful while br_taken = 1
//   perf_accepted   (macro only) number of pushes, wraps at 2^32
//   perf_stall      (macro only) cycles with in_valid = 1 and in_ready = 0
// ----------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_res,
    input  logic               alu_zf,
    input  logic [DATA_W-1:0]  store_data,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic               reg_wr,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic               is_branch,
    input  logic [DATA_W-1:0]  br_tgt_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_res,
    output logic [DATA_W-1:0]  out_sdata,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_reg_wr,
    output logic               out_mem_rd,
    output logic               out_mem_wr,
    output logic               br_taken,
    output logic [DATA_W-1:0]  br_target
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]        perf_accepted,
    output logic [31:0]        perf_stall
`endif
);

    localparam int ENT_W = 2 * DATA_W + RADDR_W + 3;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [ENT_W-1:0] head_q;
    logic [ENT_W-1:0] skid_q;
    logic [ENT_W-1:0] new_entry;
    logic             push;
    logic             take;
    logic             pop;

    // A flush still lets the handshake complete on the input side. The entry
    // is simply not kept.
    assign push = in_valid & in_ready;
    assign take = push & ~flush;
    assign pop  = out_valid & out_ready;

    // A branch never writes back or touches memory, so its controls are
    // cleared when the entry is captured.
    assign new_entry = {alu_res, store_data, rd_addr,
                        reg_wr & ~is_branch,
                        mem_rd & ~is_branch,
                        mem_wr & ~is_branch};

    assign {out_res, out_sdata, out_rd, out_reg_wr, out_mem_rd, out_mem_wr} = head_q;

    // State register: occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= EMPTY;
        end else begin
            count_q <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = EMPTY;
        end else begin
            case (count_q)
                EMPTY: if (push) count_d = ONE;
                ONE: begin
                    if (push && !pop)      count_d = FULL;
                    else if (pop && !push) count_d = EMPTY;
                end
                FULL:    if (pop) count_d = ONE;
                default: count_d = EMPTY;
            endcase
        end
    end

    // Output decode: in_ready depends only on the count, never on out_ready.
    always_comb begin
        in_ready  = (count_q != FULL);
        out_valid = (count_q != EMPTY);
    end

    // Entry storage. The head register drives out_* directly. The skid
    // register only holds the second entry while the stage is FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (count_q)
                EMPTY: begin
                    if (push) head_q <= new_entry;
                end
                ONE: begin
                    if (push && pop)  head_q <= new_entry;
                    if (push && !pop) skid_q <= new_entry;
                end
                FULL: begin
                    if (pop) head_q <= skid_q;
                end
                default: ;
            endcase
        end
    end

    // Branch redirect. The pulse lasts exactly one cycle after a kept taken
    // branch. The target holds its value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_taken  <= 1'b0;
            br_target <= '0;
        end else begin
            br_taken <= take & is_branch & alu_zf;
            if (take && is_branch && alu_zf) br_target <= br_tgt_in;
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    // The counters wrap naturally. flush does not clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_accepted <= '0;
            perf_stall    <= '0;
        end else begin
            if (push)                  perf_accepted <= perf_accepted + 32'd1;
            if (in_valid && !in_ready) perf_stall    <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_res = '0;
    logic        alu_zf = 1'b0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        reg_wr = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic        is_branch = 1'b0;
    logic [31:0] br_tgt_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic [31:0] out_sdata;
    logic [4:0]  out_rd;
    logic        out_reg_wr;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic        br_taken;
    logic [31:0] br_target;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] perf_accepted;
    logic [31:0] perf_stall;
`endif

    ex_mem_stage #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_res(alu_res), .alu_zf(alu_zf), .store_data(store_data),
        .rd_addr(rd_addr), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .is_branch(is_branch), .br_tgt_in(br_tgt_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_sdata(out_sdata), .out_rd(out_rd),
        .out_reg_wr(out_reg_wr), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .br_taken(br_taken), .br_target(br_target)
`ifdef EX_MEM_PERF_CNT_EN
        , .perf_accepted(perf_accepted), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: a FIFO of entries ----------------
    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_head;
    logic        m_br;
    logic [31:0] m_tgt;

    task automatic model_reset();
        mq.delete();
        m_head = '0;
        m_br   = 1'b0;
        m_tgt  = '0;
    endtask

    // Advance the model by one clock, using the inputs present before the edge.
    task automatic model_step();
        ent_t e;
        bit rdy, vld, psh, pp;
        rdy = (mq.size() != 2);
        vld = (mq.size() != 0);
        psh = in_valid && rdy;
        pp  = vld && out_ready;
        e.res   = alu_res;
        e.sdata = store_data;
        e.rd    = rd_addr;
        e.rw    = is_branch ? 1'b0 : reg_wr;
        e.mr    = is_branch ? 1'b0 : mem_rd;
        e.mw    = is_branch ? 1'b0 : mem_wr;
        m_br = psh && !flush && is_branch && alu_zf;
        if (m_br) m_tgt = br_tgt_in;
        if (pp) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (psh) mq.push_back(e);
        if (mq.size() != 0) m_head = mq[0];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, out_valid, (mq.size() != 0));
        check({tag, ".in_ready"},  in_ready,  (mq.size() != 2));
        check({tag, ".out_res"},   out_res,   m_head.res);
        check({tag, ".out_sdata"}, out_sdata, m_head.sdata);
        check({tag, ".out_rd"},    out_rd,    m_head.rd);
        check({tag, ".out_reg_wr"}, out_reg_wr, m_head.rw);
        check({tag, ".out_mem_rd"}, out_mem_rd, m_head.mr);
        check({tag, ".out_mem_wr"}, out_mem_wr, m_head.mw);
        check({tag, ".br_taken"},  br_taken,  m_br);
        check({tag, ".br_target"}, br_target, m_tgt);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        iv, ordy, fl, isb, zf, rw;
        logic [31:0] res, tgt;
        logic [4:0]  rd;
        logic        e_ov, e_ir, e_rw, e_bt;
        logic [31:0] e_res, e_tgt;
        logic [4:0]  e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic ordy, input logic fl, input logic isb, input logic zf,
        input logic [31:0] res, input logic [4:0] rd, input logic rw, input logic [31:0] tgt,
        input logic e_ov, input logic e_ir, input logic [31:0] e_res, input logic [4:0] e_rd,
        input logic e_rw, input logic e_bt, input logic [31:0] e_tgt);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.isb = isb; v.zf = zf;
        v.res = res; v.rd = rd; v.rw = rw; v.tgt = tgt;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_res = e_res; v.e_rd = e_rd;
        v.e_rw = e_rw; v.e_bt = e_bt; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid   = v.iv;
        out_ready  = v.ordy;
        flush      = v.fl;
        is_branch  = v.isb;
        alu_zf     = v.zf;
        alu_res    = v.res;
        store_data = v.res ^ 32'hFFFF_0000;
        rd_addr    = v.rd;
        reg_wr     = v.rw;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        br_tgt_in  = v.tgt;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; is_branch = 1'b0;
        alu_zf = 1'b0; reg_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    vec_t tbl[19];

    initial begin
        //                iv ordy fl isb zf  res     rd rw tgt      | ov ir res   rd rw bt tgt
        tbl[0]  = mk(1, 1, 0, 0, 0, 32'h5,  3, 1, 32'h0,   1, 1, 32'h5,  3, 1, 0, 32'h0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h5,  3, 1, 0, 32'h0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 32'h11, 1, 1, 32'h0,   1, 1, 32'h11, 1, 1, 0, 32'h0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 32'h22, 2, 1, 32'h0,   1, 0, 32'h11, 1, 1, 0, 32'h0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 32'h33, 4, 1, 32'h0,   1, 0, 32'h11, 1, 1, 0, 32'h0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 32'h33, 4, 1, 32'h0,   1, 1, 32'h22, 2, 1, 0, 32'h0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 32'h33, 4, 1, 32'h0,   1, 1, 32'h33, 4, 1, 0, 32'h0);
        tbl[7]  = mk(0, 1, 0, 0, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h33, 4, 1, 0, 32'h0);
        tbl[8]  = mk(1, 0, 0, 1, 1, 32'h0,  7, 1, 32'h40,  1, 1, 32'h0,  7, 0, 1, 32'h40);
        tbl[9]  = mk(0, 1, 0, 0, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h0,  7, 0, 0, 32'h40);
        tbl[10] = mk(1, 1, 0, 1, 0, 32'h9,  6, 1, 32'h80,  1, 1, 32'h9,  6, 0, 0, 32'h40);
        tbl[11] = mk(0, 1, 0, 0, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h9,  6, 0, 0, 32'h40);
        tbl[12] = mk(1, 0, 0, 0, 0, 32'hA1, 1, 1, 32'h0,   1, 1, 32'hA1, 1, 1, 0, 32'h40);
        tbl[13] = mk(1, 0, 0, 0, 0, 32'hA2, 2, 1, 32'h0,   1, 0, 32'hA1, 1, 1, 0, 32'h40);
        tbl[14] = mk(1, 0, 1, 1, 1, 32'hA3, 3, 1, 32'hC0,  0, 1, 32'hA1, 1, 1, 0, 32'h40);
        tbl[15] = mk(1, 0, 0, 0, 0, 32'hB1, 5, 1, 32'h0,   1, 1, 32'hB1, 5, 1, 0, 32'h40);
        tbl[16] = mk(1, 0, 1, 1, 1, 32'hB2, 6, 1, 32'hC4,  0, 1, 32'hB1, 5, 1, 0, 32'h40);
        tbl[17] = mk(1, 1, 0, 1, 1, 32'hD0, 8, 1, 32'h50,  1, 1, 32'hD0, 8, 0, 1, 32'h50);
        tbl[18] = mk(0, 1, 1, 0, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'hD0, 8, 0, 0, 32'h50);
    end

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        idle();
        repeat (3) @(posedge clk);
        #3;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.in_ready",  in_ready,  1'b1);
        check("rst.br_taken",  br_taken,  1'b0);
        check("rst.out_res",   out_res,   32'h0);
        check("rst.br_target", br_target, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i]);
            tick();
            check($sformatf("vec%0d.out_valid", i),  out_valid,  tbl[i].e_ov);
            check($sformatf("vec%0d.in_ready", i),   in_ready,   tbl[i].e_ir);
            check($sformatf("vec%0d.out_res", i),    out_res,    tbl[i].e_res);
            check($sformatf("vec%0d.out_rd", i),     out_rd,     tbl[i].e_rd);
            check($sformatf("vec%0d.out_reg_wr", i), out_reg_wr, tbl[i].e_rw);
            check($sformatf("vec%0d.br_taken", i),   br_taken,   tbl[i].e_bt);
            check($sformatf("vec%0d.br_target", i),  br_target,  tbl[i].e_tgt);
        end

        // Asynchronous reset in the middle of a cycle, with the stage full and a pulse pending
        drive(mk(1, 0, 0, 0, 0, 32'hE1, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mk(1, 0, 0, 1, 1, 32'hE2, 2, 1, 32'h60, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check("arst.pre_in_ready", in_ready, 1'b0);
        check("arst.pre_br_taken", br_taken, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", out_valid, 1'b0);
        check("arst.in_ready",  in_ready,  1'b1);
        check("arst.br_taken",  br_taken,  1'b0);
        check("arst.out_res",   out_res,   32'h0);
        check("arst.br_target", br_target, 32'h0);
        model_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;

`ifdef EX_MEM_PERF_CNT_EN
        // 3 pushes and 4 stalled cycles
        drive(mk(1, 0, 0, 0, 0, 32'h1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); tick();
        drive(mk(1, 0, 0, 0, 0, 32'h2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0)); tick();
        repeat (4) tick();
        drive(mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); tick();
        drive(mk(1, 1, 0, 0, 0, 32'h3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0)); tick();
        check("perf.accepted", perf_accepted, 32'd3);
        check("perf.stall",    perf_stall,    32'd4);
        check_model("perf");
        idle();
`endif

        // Randomized traffic checked against the FIFO model
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            is_branch  = ($urandom_range(0, 3) == 0);
            alu_zf     = $urandom_range(0, 1);
            alu_res    = $urandom;
            store_data = $urandom;
            rd_addr    = 5'($urandom);
            reg_wr     = $urandom_range(0, 1);
            mem_rd     = $urandom_range(0, 1);
            mem_wr     = $urandom_range(0, 1);
            br_tgt_in  = $urandom;
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
